// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the nibble-serial add/sub unit
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NIB_W = 4;

endpackage

// File: rtl/adder4.sv
// rtl/adder4.sv - 4-bit carry-lookahead adder slice
module adder4
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is a flat function of g/p/cin, no ripple between bits.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[NIB_W-1:0];
  assign cout_o = c[NIB_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - sequential add/subtract, one nibble per clock through adder4
module nibble_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]       a_sh_q, a_sh_d;
  logic [WIDTH-1:0]       b_sh_q, b_sh_d;
  logic [WIDTH-NIB_W-1:0] res_sh_q, res_sh_d;
  logic                   carry_reg_q, carry_reg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   msb_a_q, msb_a_d;
  logic                   msb_b_q, msb_b_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   carry_q, carry_d;
  logic                   ovf_q, ovf_d;
  logic                   zero_q, zero_d;
  logic                   neg_q, neg_d;

  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] full_sum;
  logic             accept;
  logic             last_nib;

  adder4 u_adder4 (
    .a_i    (a_sh_q[NIB_W-1:0]),
    .b_i    (b_sh_q[NIB_W-1:0]),
    .cin_i  (carry_reg_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  assign b_eff    = (op_sub == OP_SUB) ? ~b : b;
  assign accept   = (state_q == IDLE) && start_valid;
  assign last_nib = (state_q == RUN) && (cnt_q == LAST_CNT);
  // Previously produced nibbles sit below the one coming out of the slice now.
  assign full_sum = {nib_sum, res_sh_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
  end

  always_comb begin
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    carry_reg_d = carry_reg_q;
    cnt_d       = cnt_q;
    msb_a_d     = msb_a_q;
    msb_b_d     = msb_b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;

    if (accept) begin
      a_sh_d      = a;
      b_sh_d      = b_eff;
      carry_reg_d = (op_sub == OP_SUB);
      cnt_d       = '0;
      msb_a_d     = a[WIDTH-1];
      msb_b_d     = b_eff[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh_d      = a_sh_q >> NIB_W;
      b_sh_d      = b_sh_q >> NIB_W;
      res_sh_d    = full_sum[WIDTH-1:NIB_W];
      carry_reg_d = nib_cout;
      cnt_d       = cnt_q + CNT_W'(1);
      // Visible outputs change only here so they hold through DONE and IDLE.
      if (last_nib) begin
        result_d = full_sum;
        carry_d  = nib_cout;
        ovf_d    = (msb_a_q == msb_b_q) && (full_sum[WIDTH-1] != msb_a_q);
        zero_d   = (full_sum == '0);
        neg_d    = full_sum[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      carry_reg_q <= 1'b0;
      cnt_q       <= '0;
      msb_a_q     <= 1'b0;
      msb_b_q     <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      carry_reg_q <= carry_reg_d;
      cnt_q       <= cnt_d;
      msb_a_q     <= msb_a_d;
      msb_b_q     <= msb_b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - self-checking bench for nibble_serial_addsub
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks;
  int failures;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero),
    .negative    (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic op, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] r, output logic c, output logic v,
                       output logic z, output logic n);
    int ua, ub, sa, sb, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (op) begin
      r  = 16'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = 16'(ua + ub);
      c  = ((ua + ub) > 65535);
      sr = sa + sb;
    end
    v = (sr > 32767) || (sr < -32768);
    z = (r == 16'h0000);
    n = r[15];
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                         input logic v, input logic z, input logic n);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_carry"}, 32'(carry), 32'(c));
    chk({tag, "_overflow"}, 32'(overflow), 32'(v));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_negative"}, 32'(negative), 32'(n));
  endtask

  // Called just after the accept edge; returns in IDLE if res_ready is high, else in DONE.
  task automatic wait_result(input string tag, input logic op, input logic [15:0] av,
                             input logic [15:0] bv);
    logic [15:0] er;
    logic ec, ev, ez, en;
    int n;
    model(op, av, bv, er, ec, ev, ez, en);
    n = 0;
    while (res_valid !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_sr_done"}, 32'(start_ready), 32'd0);
    chk_out(tag, er, ec, ev, ez, en);
    start_valid = 1'b0;
    if (res_ready) begin
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      chk({tag, "_sr_idle"}, 32'(start_ready), 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [15:0] av,
                        input logic [15:0] bv);
    @(negedge clk);
    start_valid = 1'b1;
    op_sub      = op;
    a           = av;
    b           = bv;
    @(posedge clk); #1;
    chk({tag, "_accept"}, 32'(start_ready), 32'd0);
    // Noise on the request side while busy must be ignored.
    start_valid = 1'($urandom);
    op_sub      = 1'($urandom);
    a           = 16'($urandom);
    b           = 16'($urandom);
    wait_result(tag, op, av, bv);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rop;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_sub      = 1'b0;
    a           = 16'h0;
    b           = 16'h0;
    res_ready   = 1'b1;

    #2;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic", 1'b0, 16'h1234, 16'h0FED);
    chk_out("t1", 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 1'b1, 16'h0005, 16'h0007);
    chk_out("t2", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001);
    chk_out("t3a", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001);
    chk_out("t3b", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001);
    chk_out("t4a", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_equal", 1'b1, 16'h1234, 16'h1234);
    chk_out("t4b", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure: hold DONE, poke requests, then release.
    res_ready = 1'b0;
    run_op("bp", 1'b0, 16'h4000, 16'h4000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_sr", 32'(start_ready), 32'd0);
      chk_out("bp_hold", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    @(negedge clk);
    res_ready   = 1'b1;
    start_valid = 1'b1;
    op_sub      = 1'b1;
    a           = 16'h0100;
    b           = 16'h0001;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_release_sr", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_new_accept", 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    wait_result("bp_next", 1'b1, 16'h0100, 16'h0001);
    chk_out("bp_next_c", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after two RUN edges, asserted between clock edges.
    @(negedge clk);
    start_valid = 1'b1;
    op_sub      = 1'b0;
    a           = 16'h8421;
    b           = 16'h1111;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sr", 32'(start_ready), 32'd1);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk_out("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(res_valid), 32'd0);
    end
    run_op("post_rst_op", 1'b1, 16'h0003, 16'h8000);

    for (int i = 0; i < 16; i++) begin
      rop = 1'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i == 0) ra = 16'h8000;
      if (i == 1) rb = 16'hFFFF;
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
